rob_nwide: RTL and testbench

- Parametrised reorder buffer; successor to the fixed 2-retire ROB.
- Sits between the decode buffer / rename stage and the free pool.
- Allocates one entry per dispatched instruction and marks entries done from NUM_BUS writeback buses.
- Retires up to RETIRE_W consecutive done entries per cycle in program order, returning old physical tags to the free pool.

---
 rtl/rob_pkg.sv | 24 ++
 rtl/rob_retire_select.sv | 28 ++
 rtl/rob_nwide.sv | 131 +++++++++++++
 tb/tb_rob_nwide.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and writeback-bus field layout for the reorder buffer.
package rob_pkg;

   localparam int unsigned BUS_VALID  = 38;
   localparam int unsigned BUS_RES_HI = 37;
   localparam int unsigned BUS_RES_LO = 6;
   localparam int unsigned BUS_TAG_HI = 5;
   localparam int unsigned BUS_TAG_LO = 0;
   localparam int unsigned BUS_WIDTH  = 39;

   // Entry field widths; the bus tag field bounds the physical tag width.
   localparam int unsigned TAG_W    = BUS_TAG_HI - BUS_TAG_LO + 1;
   localparam int unsigned ENT_PC_W = 12;

   typedef struct packed {
      logic                valid;
      logic                done;
      logic                has_dest;
      logic [TAG_W-1:0]    rd;
      logic [TAG_W-1:0]    rd_old;
      logic [ENT_PC_W-1:0] pc;
   } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// Picks the in-order retirable prefix from a head-rotated ready vector.
module rob_retire_select
   import rob_pkg::*;
#(
   parameter int unsigned RETIRE_W = 2,
   parameter int unsigned CNT_W    = 5
) (
   input  logic [RETIRE_W-1:0] rdy_i,
   input  logic [CNT_W-1:0]    count_i,
   output logic [RETIRE_W-1:0] mask_o,
   output logic [2:0]          num_o
);

   logic run;

   always_comb begin
      run    = 1'b1;
      mask_o = '0;
      num_o  = '0;
      // First not-ready slot blocks every younger slot.
      for (int unsigned i = 0; i < RETIRE_W; i++) begin
         run       = run & rdy_i[i] & (CNT_W'(i) < count_i);
         mask_o[i] = run;
         num_o     = num_o + 3'(run);
      end
   end

endmodule

// File: rtl/rob_nwide.sv
// N-wide reorder buffer: dispatch, multi-bus writeback, in-order retire.
// Optional macro ROB_FLUSH_EN adds a flush port that empties the buffer.
module rob_nwide
   import rob_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned RETIRE_W = 2,
   parameter int unsigned NUM_BUS  = 3,
   parameter int unsigned PREG_W   = 6,
   parameter int unsigned PC_W     = 12,
   parameter int unsigned PTR_W    = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  logic [PREG_W-1:0]          disp_rd,
   input  logic [PREG_W-1:0]          disp_rd_old,
   input  logic [PC_W-1:0]            disp_pc,
   input  logic                       disp_has_dest,
   output logic [PTR_W-1:0]           rob_num,
   input  logic [NUM_BUS*BUS_WIDTH-1:0] bus,
   output logic [RETIRE_W-1:0]        ret_valid,
   output logic [RETIRE_W-1:0]        ret_has_dest,
   output logic [RETIRE_W*PREG_W-1:0] ret_rd_old,
   output logic [RETIRE_W*PC_W-1:0]   ret_pc,
`ifdef ROB_FLUSH_EN
   input  logic                       flush,
`endif
   output logic [PTR_W:0]             count
);

   rob_entry_t           ent_q [DEPTH];
   rob_entry_t           ent_d [DEPTH];
   logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]       count_q, count_d;
   logic [BUS_WIDTH-1:0] bus_w [NUM_BUS];
   logic [RETIRE_W-1:0]  rdy, ret_mask;
   logic [2:0]           ret_num;
   logic                 fire, hit;
   logic                 unused_bus;

   assign unused_bus = ^bus;

   for (genvar k = 0; k < NUM_BUS; k++) begin : g_bus
      assign bus_w[k] = bus[k*BUS_WIDTH +: BUS_WIDTH];
   end

   for (genvar i = 0; i < RETIRE_W; i++) begin : g_slot
      rob_entry_t e;
      assign e       = ent_q[head_q + PTR_W'(i)];
      assign rdy[i]  = e.valid & e.done;
      assign ret_has_dest[i]               = e.has_dest;
      assign ret_rd_old[i*PREG_W +: PREG_W] = PREG_W'(e.rd_old);
      assign ret_pc[i*PC_W +: PC_W]         = PC_W'(e.pc);
   end

   rob_retire_select #(
      .RETIRE_W (RETIRE_W),
      .CNT_W    (PTR_W + 1)
   ) u_sel (
      .rdy_i   (rdy),
      .count_i (count_q),
      .mask_o  (ret_mask),
      .num_o   (ret_num)
   );

   assign disp_ready = count_q < (PTR_W+1)'(DEPTH);
   assign fire       = disp_valid & disp_ready;
   assign rob_num    = tail_q;
   assign count      = count_q;
`ifdef ROB_FLUSH_EN
   assign ret_valid  = flush ? '0 : ret_mask;
`else
   assign ret_valid  = ret_mask;
`endif

   always_comb begin
      ent_d   = ent_q;
      head_d  = head_q + PTR_W'(ret_num);
      tail_d  = tail_q;
      count_d = count_q + (PTR_W+1)'(fire) - (PTR_W+1)'(ret_num);
      hit     = 1'b0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
         hit = 1'b0;
         for (int unsigned k = 0; k < NUM_BUS; k++)
            if (bus_w[k][BUS_VALID] && bus_w[k][BUS_TAG_HI:BUS_TAG_LO] == ent_q[e].rd)
               hit = 1'b1;
         if (ent_q[e].valid && ent_q[e].has_dest && !ent_q[e].done && hit)
            ent_d[e].done = 1'b1;
      end
      for (int unsigned i = 0; i < RETIRE_W; i++)
         if (ret_mask[i]) begin
            ent_d[head_q + PTR_W'(i)].valid = 1'b0;
            ent_d[head_q + PTR_W'(i)].done  = 1'b0;
         end
      // The tail slot is never valid when dispatch fires, so it cannot match a bus.
      if (fire) begin
         ent_d[tail_q] = '{valid: 1'b1, done: !disp_has_dest, has_dest: disp_has_dest,
                           rd: TAG_W'(disp_rd), rd_old: TAG_W'(disp_rd_old),
                           pc: ENT_PC_W'(disp_pc)};
         tail_d = tail_q + PTR_W'(1);
      end
`ifdef ROB_FLUSH_EN
      if (flush) begin
         for (int unsigned e = 0; e < DEPTH; e++) begin
            ent_d[e].valid = 1'b0;
            ent_d[e].done  = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned e = 0; e < DEPTH; e++) ent_q[e] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         ent_q   <= ent_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_rob_nwide.sv
// Randomised and directed bench for rob_nwide against a queue-based model.
module tb_rob_nwide;

   localparam int DEPTH = 16;
   localparam int RW    = 2;
   localparam int NB    = 3;
   localparam int PW    = 6;
   localparam int CW    = 12;
   localparam int PTRW  = 4;
   localparam int BW    = 39;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              disp_valid = 1'b0;
   logic              disp_ready;
   logic [PW-1:0]     disp_rd = '0;
   logic [PW-1:0]     disp_rd_old = '0;
   logic [CW-1:0]     disp_pc = '0;
   logic              disp_has_dest = 1'b0;
   logic [PTRW-1:0]   rob_num;
   logic [NB*BW-1:0]  bus = '0;
   logic [RW-1:0]     ret_valid;
   logic [RW-1:0]     ret_has_dest;
   logic [RW*PW-1:0]  ret_rd_old;
   logic [RW*CW-1:0]  ret_pc;
   logic [PTRW:0]     count;
`ifdef ROB_FLUSH_EN
   logic              flush = 1'b0;
`endif

   rob_nwide #(.DEPTH(DEPTH), .RETIRE_W(RW), .NUM_BUS(NB), .PREG_W(PW), .PC_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .disp_valid    (disp_valid),
      .disp_ready    (disp_ready),
      .disp_rd       (disp_rd),
      .disp_rd_old   (disp_rd_old),
      .disp_pc       (disp_pc),
      .disp_has_dest (disp_has_dest),
      .rob_num       (rob_num),
      .bus           (bus),
      .ret_valid     (ret_valid),
      .ret_has_dest  (ret_has_dest),
      .ret_rd_old    (ret_rd_old),
      .ret_pc        (ret_pc),
`ifdef ROB_FLUSH_EN
      .flush         (flush),
`endif
      .count         (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] rd;
      logic [PW-1:0] rd_old;
      logic [CW-1:0] pc;
      bit            hd;
      bit            done;
   } ment_t;

   ment_t mq[$];
   int    m_tail;
   int    checks   = 0;
   int    failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_nret();
      int n = 0;
      while (n < RW && n < mq.size() && mq[n].done) n++;
      return n;
   endfunction

   function automatic logic [NB*BW-1:0] mk_bus(bit v0, logic [5:0] t0, bit v1, logic [5:0] t1,
                                                bit v2, logic [5:0] t2);
      logic [NB*BW-1:0] b;
      logic [31:0]      r;
      bit               v [3];
      logic [5:0]       t [3];
      v[0] = v0; v[1] = v1; v[2] = v2;
      t[0] = t0; t[1] = t1; t[2] = t2;
      for (int k = 0; k < NB; k++) begin
         r = $urandom;
         b[k*BW +: BW] = {v[k], r, t[k]};
      end
      return b;
   endfunction

   task automatic compare_outputs(input string tag);
      int          n = exp_nret();
      logic [31:0] m = (32'd1 << n) - 32'd1;
      check({tag, ".count"}, 32'(count), 32'(mq.size()));
      check({tag, ".disp_ready"}, 32'(disp_ready), 32'(mq.size() < DEPTH));
      check({tag, ".rob_num"}, 32'(rob_num), 32'(m_tail));
      check({tag, ".ret_valid"}, 32'(ret_valid), m);
      for (int i = 0; i < n; i++) begin
         check({tag, ".ret_pc"}, 32'(ret_pc[i*CW +: CW]), 32'(mq[i].pc));
         check({tag, ".ret_rd_old"}, 32'(ret_rd_old[i*PW +: PW]), 32'(mq[i].rd_old));
         check({tag, ".ret_has_dest"}, 32'(ret_has_dest[i]), 32'(mq[i].hd));
      end
   endtask

   // Drive one cycle of inputs, advance the model, then check after the edge.
   task automatic step(input string tag, input bit dv, input logic [5:0] rd, input logic [5:0] rdo,
                       input logic [11:0] pc, input bit hd, input logic [NB*BW-1:0] b, input bit fl);
      int    nret;
      bit    fire;
      ment_t ne;
      disp_valid = dv; disp_rd = rd; disp_rd_old = rdo; disp_pc = pc; disp_has_dest = hd; bus = b;
`ifdef ROB_FLUSH_EN
      flush = fl;
      if (fl) begin
         #1;
         check({tag, ".flush_ret_valid"}, 32'(ret_valid), 32'd0);
      end
`endif
      nret = exp_nret();
      fire = dv && (mq.size() < DEPTH);
      if (fl) begin
         mq.delete();
         m_tail = 0;
      end else begin
         for (int k = 0; k < NB; k++)
            if (b[k*BW + 38])
               foreach (mq[j])
                  if (mq[j].hd && mq[j].rd == b[k*BW +: 6]) mq[j].done = 1'b1;
         for (int i = 0; i < nret; i++) void'(mq.pop_front());
         if (fire) begin
            ne.rd = rd; ne.rd_old = rdo; ne.pc = pc; ne.hd = hd; ne.done = !hd;
            mq.push_back(ne);
            m_tail = (m_tail + 1) % DEPTH;
         end
      end
      @(posedge clk);
      @(negedge clk);
`ifdef ROB_FLUSH_EN
      flush = 1'b0;
`endif
      disp_valid = 1'b0;
      bus = '0;
      compare_outputs(tag);
   endtask

   task automatic do_reset();
      rst = 1'b0; disp_valid = 1'b0; bus = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      mq.delete();
      m_tail = 0;
      compare_outputs("reset");
   endtask

   initial begin
      logic [NB*BW-1:0] nobus;
      nobus = '0;

      // Fill to full; a further dispatch is dropped.
      do_reset();
      for (int i = 0; i < 16; i++) step("fill", 1, 6'(32 + i), 6'(i), 12'(12'h100 + i), 1, nobus, 0);
      check("full.count", 32'(count), 32'd16);
      check("full.disp_ready", 32'(disp_ready), 32'd0);
      step("full17", 1, 6'd48, 6'd1, 12'h1ff, 1, nobus, 0);
      check("full17.rob_num", 32'(rob_num), 32'd0);
      check("full17.count", 32'(count), 32'd16);

      // Out-of-order completion blocks retirement until the head is done.
      do_reset();
      for (int i = 0; i < 3; i++) step("ooo_disp", 1, 6'(40 + i), 6'(10 + i), 12'(12'h020 + i), 1, nobus, 0);
      step("ooo_b41", 0, '0, '0, '0, 0, mk_bus(0, 0, 1, 41, 0, 0), 0);
      check("ooo.blocked", 32'(ret_valid), 32'd0);
      step("ooo_b40", 0, '0, '0, '0, 0, mk_bus(0, 0, 1, 40, 0, 0), 0);
      check("ooo.ret2", 32'(ret_valid), 32'b11);
      step("ooo_idle", 0, '0, '0, '0, 0, nobus, 0);
      check("ooo.pending", 32'(ret_valid), 32'd0);
      check("ooo.count", 32'(count), 32'd1);

      // Store without destination is done at dispatch.
      do_reset();
      step("store", 1, 6'd0, 6'd0, 12'h010, 0, nobus, 0);
      check("store.ret_valid", 32'(ret_valid), 32'd1);
      check("store.has_dest", 32'(ret_has_dest[0]), 32'd0);
      check("store.pc", 32'(ret_pc[CW-1:0]), 32'h010);
      step("store_idle", 0, '0, '0, '0, 0, nobus, 0);
      check("store.empty", 32'(count), 32'd0);

      // Full buffer drained 2/cycle while dispatching 1/cycle across the wrap.
      do_reset();
      for (int i = 0; i < 16; i++) step("wrap_fill", 1, 6'(32 + i), 6'(i), 12'(12'h200 + i), 1, nobus, 0);
      for (int c = 0; c < 6; c++)
         step("wrap_done", 0, '0, '0, '0, 0,
              mk_bus(1, 6'(32 + 3*c), 1, 6'(33 + 3*c), (3*c + 2) < 16, 6'(34 + 3*c)), 0);
      for (int c = 0; c < 24; c++)
         step("wrap_run", 1, 6'(c), 6'(c), 12'(12'h300 + c), 0, nobus, 0);

      // Two buses carrying the same tag mark the entry once.
      do_reset();
      step("dual_disp", 1, 6'd45, 6'd7, 12'h045, 1, nobus, 0);
      step("dual_bus", 0, '0, '0, '0, 0, mk_bus(1, 45, 0, 0, 1, 45), 0);
      check("dual.ret_valid", 32'(ret_valid), 32'd1);
      check("dual.rd_old", 32'(ret_rd_old[PW-1:0]), 32'd7);
      step("dual_idle", 0, '0, '0, '0, 0, nobus, 0);
      check("dual.count", 32'(count), 32'd0);

`ifdef ROB_FLUSH_EN
      do_reset();
      for (int i = 0; i < 5; i++) step("fl_disp", 1, 6'(32 + i), 6'(i), 12'(12'h400 + i), 1, nobus, 0);
      step("fl_done", 0, '0, '0, '0, 0, mk_bus(1, 32, 0, 0, 0, 0), 0);
      step("flush", 1, 6'd50, 6'd3, 12'h4ff, 1, nobus, 1);
      check("flush.count", 32'(count), 32'd0);
      check("flush.rob_num", 32'(rob_num), 32'd0);
`endif

      // Random traffic.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bit fl;
         fl = 1'b0;
`ifdef ROB_FLUSH_EN
         fl = ($urandom % 64) == 0;
`endif
         step("rand", ($urandom % 4) != 0, 6'(32 + $urandom % 16), 6'($urandom), 12'($urandom),
              ($urandom % 4) != 0,
              mk_bus($urandom % 2, 6'(32 + $urandom % 16), $urandom % 2, 6'(32 + $urandom % 16),
                     $urandom % 2, 6'(32 + $urandom % 16)), fl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
